// File: rtl/button_reader.sv
// Pushbutton front end: 2-FF synchroniser, polarity normalisation and a
// debounce FSM producing a clean level, press/release/long-press strobes and a press count.
module button_reader #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int LONG_CYCLES     = 100_000_000,
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter int CNT_W           = 8
) (
  input  logic             sysClk_i,
  input  logic             rst_i,
  input  logic             btn_i,
  output logic             pressed_o,
  output logic             press_o,
  output logic             release_o,
  output logic             long_press_o,
  output logic [CNT_W-1:0] press_count_o
);

  localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HOLD_W = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
  localparam logic [DB_W-1:0]   DB_MAX   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES - 1);
  localparam logic INACTIVE_PIN = ACTIVE_LOW;

  typedef enum logic [1:0] {
    RELEASED   = 2'd0,
    DB_PRESS   = 2'd1,
    PRESSED    = 2'd2,
    DB_RELEASE = 2'd3
  } state_e;

  logic              sync1_q;
  logic              sync2_q;
  logic              act_s;
  state_e            state_q;
  logic [DB_W-1:0]   db_t_q;
  logic [HOLD_W-1:0] hold_t_q;
  logic              long_done_q;
  logic              pressed_q;
  logic              press_q;
  logic              release_q;
  logic              long_press_q;
  logic [CNT_W-1:0]  press_count_q;

  // Synchroniser resets to the idle pin level so reset never looks like a press.
  always_ff @(posedge sysClk_i) begin
    if (rst_i) begin
      sync1_q <= INACTIVE_PIN;
      sync2_q <= INACTIVE_PIN;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

  assign act_s = ACTIVE_LOW ? ~sync2_q : sync2_q;

  // Debounce FSM, hold timer and registered outputs.
  always_ff @(posedge sysClk_i) begin
    if (rst_i) begin
      state_q       <= RELEASED;
      db_t_q        <= '0;
      hold_t_q      <= '0;
      long_done_q   <= 1'b0;
      pressed_q     <= 1'b0;
      press_q       <= 1'b0;
      release_q     <= 1'b0;
      long_press_q  <= 1'b0;
      press_count_q <= '0;
    end else begin
      press_q      <= 1'b0;
      release_q    <= 1'b0;
      long_press_q <= 1'b0;

      case (state_q)
        RELEASED: begin
          if (act_s) begin
            state_q <= DB_PRESS;
            db_t_q  <= '0;
          end
        end
        DB_PRESS: begin
          if (!act_s) begin
            state_q <= RELEASED;
          end else if (db_t_q == DB_MAX) begin
            state_q       <= PRESSED;
            press_q       <= 1'b1;
            pressed_q     <= 1'b1;
            press_count_q <= press_count_q + CNT_W'(1);
            hold_t_q      <= '0;
            long_done_q   <= 1'b0;
          end else begin
            db_t_q <= db_t_q + DB_W'(1);
          end
        end
        PRESSED: begin
          if (!act_s) begin
            state_q <= DB_RELEASE;
            db_t_q  <= '0;
          end
        end
        DB_RELEASE: begin
          // A bounce back to pressed keeps the hold timer running.
          if (act_s) begin
            state_q <= PRESSED;
          end else if (db_t_q == DB_MAX) begin
            state_q   <= RELEASED;
            release_q <= 1'b1;
            pressed_q <= 1'b0;
          end else begin
            db_t_q <= db_t_q + DB_W'(1);
          end
        end
        default: begin
          state_q <= RELEASED;
        end
      endcase

      if ((state_q == PRESSED || state_q == DB_RELEASE) && !long_done_q) begin
        if (hold_t_q == HOLD_MAX) begin
          long_press_q <= 1'b1;
          long_done_q  <= 1'b1;
        end else begin
          hold_t_q <= hold_t_q + HOLD_W'(1);
        end
      end
    end
  end

  assign pressed_o     = pressed_q;
  assign press_o       = press_q;
  assign release_o     = release_q;
  assign long_press_o  = long_press_q;
  assign press_count_o = press_count_q;

endmodule
